// File: rtl/dmem_loader.sv
// Host-to-data-memory loader: streams a host image into banked memory, lets a core
// run against it, then streams a result window back out. Optional RUN cycle counter
// is built when DMEM_LOADER_CYCCNT_EN is defined.
`ifndef MEM_W
`define MEM_W 16
`endif
`ifndef DMEMCSW
`define DMEMCSW 2
`endif
`ifndef SUBDMEMADDRW
`define SUBDMEMADDRW 3
`endif

module dmem_loader #(
    parameter int DATA_W    = `MEM_W,
    parameter int CS_W      = `DMEMCSW,
    parameter int ADDR_W    = `SUBDMEMADDRW,
    parameter int RES_BASE  = 0,
    parameter int RES_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [DATA_W-1:0] host_dat,
    input  logic              host_last,
    output logic              t_cs,
    input  logic              core_rw,
    input  logic [CS_W-1:0]   core_cs,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_dat,
    output logic              dmem_rw,
    output logic [CS_W-1:0]   dmem_cs,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdat,
    input  logic [DATA_W-1:0] dmem_rdat,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_dat,
    output logic              busy,
    output logic [31:0]       run_cycles
);

    localparam int LIN_W = CS_W + ADDR_W;
    localparam logic [LIN_W-1:0] BASE      = LIN_W'(RES_BASE);
    localparam logic [LIN_W:0]   LAST_WORD = (LIN_W + 1)'(RES_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        RD_REQ,
        RD_WAIT,
        RD_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [LIN_W-1:0] ptr;
    logic [LIN_W:0]   res_cnt;
    logic             done;

    assign done = (state_q == RUN) && !core_rw && (&core_cs) && (&core_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output and state_d gets a default before the case; any path that
    // skips an assignment would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        t_cs       = 1'b0;
        host_ready = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b0;
        dmem_rw    = 1'b1;
        dmem_cs    = '0;
        dmem_addr  = '0;
        dmem_wdat  = '0;
        // Outputs are forced idle while reset is high, not just after the edge.
        if (!reset) begin
            busy = (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (start) state_d = LOAD;
                end
                LOAD: begin
                    host_ready = 1'b1;
                    if (host_valid) begin
                        dmem_rw              = 1'b0;
                        {dmem_cs, dmem_addr} = ptr;
                        dmem_wdat            = host_dat;
                        if (host_last || (&ptr)) state_d = RUN;
                    end
                end
                RUN: begin
                    t_cs      = 1'b1;
                    dmem_rw   = core_rw;
                    dmem_cs   = core_cs;
                    dmem_addr = core_addr;
                    dmem_wdat = core_dat;
                    if (done) state_d = RD_REQ;
                end
                RD_REQ: begin
                    {dmem_cs, dmem_addr} = ptr;
                    state_d              = RD_WAIT;
                end
                RD_WAIT: begin
                    state_d = RD_OUT;
                end
                RD_OUT: begin
                    res_valid = 1'b1;
                    if (res_ready) state_d = (res_cnt == LAST_WORD) ? IDLE : RD_REQ;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            res_cnt <= '0;
            res_dat <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) ptr <= '0;
                end
                LOAD: begin
                    // Saturate at the top address so a full image never wraps onto 0.
                    if (host_valid && !(&ptr)) ptr <= ptr + 1'b1;
                end
                RUN: begin
                    if (done) begin
                        ptr     <= BASE;
                        res_cnt <= '0;
                    end
                end
                RD_WAIT: begin
                    res_dat <= dmem_rdat;
                end
                RD_OUT: begin
                    if (res_ready && (res_cnt != LAST_WORD)) begin
                        ptr     <= ptr + 1'b1;
                        res_cnt <= res_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DMEM_LOADER_CYCCNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            cyc_q <= '0;
        end else if ((state_q == RUN) && !(&cyc_q)) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign run_cycles = cyc_q;
`else
    assign run_cycles = '0;
`endif

endmodule
